// File: rtl/game_2048_pkg.sv
// Shared types for the 2048 input path: direction tokens, button FSM states
// and the default debounce interval.
package game_2048_pkg;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'd0,
        DIR_UP    = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PRESS_DB = 3'd1,
        ST_ISSUE    = 3'd2,
        ST_WAIT_REL = 3'd3,
        ST_REL_DB   = 3'd4
    } btn_state_t;

    // 20 ms at 50 MHz
    localparam int DEBOUNCE_CYCLES_DEFAULT = 1_000_000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer, WIDTH bits wide, with a configurable reset value so
// that idle-high inputs come out of reset in their inactive level.
module sync_2ff #(
    parameter int              WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/button_move_encoder.sv
// Debounces the four raw buttons and turns each physical press into exactly
// one direction token handed to the game core over valid/ready.
//   state    | meaning
//   IDLE     | waiting for a press while moves are enabled
//   PRESS_DB | candidate mask must stay stable DEBOUNCE_CYCLES cycles
//   ISSUE    | token offered, held until the consumer takes it
//   WAIT_REL | waiting for all buttons released
//   REL_DB   | release must stay stable DEBOUNCE_CYCLES cycles
module button_move_encoder
    import game_2048_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] buttons,
    input  logic       move_en,
    input  logic       move_ready,
    output logic       move_valid,
    output logic [1:0] move_dir,
    output logic       pressed
);

    localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0] btn_sync;
    logic [3:0] p;

    btn_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       cand_q, cand_d;
    dir_t             dir_q, dir_d;
    logic             discard_q, discard_d;
    logic             cand_onehot;
    dir_t             cand_dir;

    sync_2ff #(
        .WIDTH    (4),
        .RESET_VAL(4'b1111)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (buttons),
        .q  (btn_sync)
    );

    assign p = ~btn_sync;

    assign cand_onehot = (cand_q != 4'd0) && ((cand_q & (cand_q - 4'd1)) == 4'd0);

    always_comb begin
        cand_dir = DIR_RIGHT;
        case (cand_q)
            4'b0010: cand_dir = DIR_UP;
            4'b0100: cand_dir = DIR_DOWN;
            4'b1000: cand_dir = DIR_LEFT;
            default: cand_dir = DIR_RIGHT;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cand_d    = cand_q;
        dir_d     = dir_q;
        discard_d = discard_q;
        case (state_q)
            ST_IDLE: begin
                // A press that began while moves were disabled stays ignored until released.
                if (p == 4'd0) begin
                    discard_d = 1'b0;
                end else if (!discard_q) begin
                    if (move_en) begin
                        cand_d  = p;
                        cnt_d   = '0;
                        state_d = ST_PRESS_DB;
                    end else begin
                        discard_d = 1'b1;
                    end
                end
            end
            ST_PRESS_DB: begin
                if (p != cand_q) begin
                    if (p == 4'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        cand_d = p;
                        cnt_d  = '0;
                    end
                end else if (cnt_q == CNT_MAX) begin
                    if (cand_onehot) begin
                        dir_d   = cand_dir;
                        state_d = ST_ISSUE;
                    end else begin
                        state_d = ST_WAIT_REL;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_ISSUE: begin
                if (move_ready) state_d = ST_WAIT_REL;
            end
            ST_WAIT_REL: begin
                if (p == 4'd0) begin
                    cnt_d   = '0;
                    state_d = ST_REL_DB;
                end
            end
            ST_REL_DB: begin
                if (p != 4'd0) begin
                    state_d = ST_WAIT_REL;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            cand_q    <= 4'd0;
            dir_q     <= DIR_RIGHT;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cand_q    <= cand_d;
            dir_q     <= dir_d;
            discard_q <= discard_d;
        end
    end

    assign move_valid = (state_q == ST_ISSUE);
    assign move_dir   = dir_q;
    assign pressed    = (state_q == ST_ISSUE) || (state_q == ST_WAIT_REL) ||
                        (state_q == ST_REL_DB);

endmodule

// File: tb/tb_button_move_encoder.sv
// Bench for button_move_encoder with a short debounce interval: a timing table,
// hand-written corner sequences and random stimulus against a run-length model.
module tb_button_move_encoder;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] buttons = 4'hF;
    logic       move_en = 1'b1;
    logic       move_ready = 1'b1;
    logic       move_valid;
    logic [1:0] move_dir;
    logic       pressed;

    int checks = 0;
    int errors = 0;
    int tokens = 0;
    int tok_dir = 0;
    int tok_dir_or = 0;

    always #5 clk = ~clk;

    button_move_encoder #(.DEBOUNCE_CYCLES(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .buttons   (buttons),
        .move_en   (move_en),
        .move_ready(move_ready),
        .move_valid(move_valid),
        .move_dir  (move_dir),
        .pressed   (pressed)
    );

    // Reference model: pressed-mask seen by the logic lags the pins by two edges;
    // a token needs D+1 consecutive equal non-zero samples, re-arming needs D+1
    // consecutive all-released samples after the token is gone.
    logic [3:0] m_mid, m_del;
    bit         m_track, m_out, m_rel, m_ignore;
    logic [3:0] m_run_val;
    int         m_run_len, m_zrun, m_dir;

    task automatic model_edge(input logic [3:0] b, input logic en, input logic rdy, input logic r);
        logic [3:0] pv;
        if (r) begin
            m_mid = 4'd0; m_del = 4'd0;
            m_track = 0; m_out = 0; m_rel = 0; m_ignore = 0;
            m_run_val = 4'd0; m_run_len = 0; m_zrun = 0; m_dir = 0;
            return;
        end
        pv = m_del;
        if (m_out) begin
            if (rdy) begin m_out = 0; m_rel = 1; m_zrun = 0; end
        end else if (m_rel) begin
            m_zrun = (pv == 4'd0) ? m_zrun + 1 : 0;
            if (m_zrun == D + 1) m_rel = 0;
        end else if (m_track) begin
            if (pv == 4'd0) m_track = 0;
            else if (pv != m_run_val) begin m_run_val = pv; m_run_len = 1; end
            else begin
                m_run_len++;
                if (m_run_len == D + 1) begin
                    m_track = 0;
                    if ($countones(pv) == 1) begin
                        m_out = 1;
                        for (int k = 0; k < 4; k++) if (pv[k]) m_dir = k;
                    end else begin
                        m_rel = 1; m_zrun = 0;
                    end
                end
            end
        end else begin
            if (pv == 4'd0) m_ignore = 0;
            else if (!m_ignore) begin
                if (en) begin m_track = 1; m_run_val = pv; m_run_len = 1; end
                else m_ignore = 1;
            end
        end
        m_del = m_mid;
        m_mid = ~b;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic [3:0] b, input logic en, input logic rdy, input logic r);
        buttons = b; move_en = en; move_ready = rdy; rst = r;
        if (!r && move_valid && rdy) begin
            tokens++;
            tok_dir = int'(move_dir);
            tok_dir_or |= int'(move_dir);
        end
        model_edge(b, en, rdy, r);
        @(posedge clk);
        #1;
        check("model_valid", int'(move_valid), int'(m_out));
        check("model_dir", int'(move_dir), m_dir);
        check("model_pressed", int'(pressed), int'(m_out | m_rel));
    endtask

    typedef struct {
        logic [3:0] b;
        logic       v;
        logic       pr;
    } vec_t;
    vec_t tv[20];

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, n;
        bit seen;
        logic [3:0] b;
        logic en;
        int hold;

        // Press at step 0 -> valid after edge D+3 (step 6); release at step 10 -> idle after 7 edges (step 16).
        for (int i = 0; i < 20; i++) begin
            tv[i].b  = (i < 10) ? 4'b1110 : 4'b1111;
            tv[i].v  = (i == D + 2);
            tv[i].pr = (i >= D + 2) && (i <= 15);
        end

        for (int i = 0; i < 3; i++) step(4'hF, 1, 1, 1);
        check("reset_valid", int'(move_valid), 0);
        check("reset_dir", int'(move_dir), 0);
        check("reset_pressed", int'(pressed), 0);

        // 1: clean press timing table
        t0 = tokens;
        for (int i = 0; i < 20; i++) begin
            step(tv[i].b, 1, 1, 0);
            check("t1_valid", int'(move_valid), int'(tv[i].v));
            check("t1_pressed", int'(pressed), int'(tv[i].pr));
            check("t1_dir", int'(move_dir), 0);
        end
        check("t1_tokens", tokens - t0, 1);

        // 2: bounce on press and release
        t0 = tokens;
        for (int i = 0; i < 10; i++) step(((i / 2) % 2 == 0) ? 4'b1101 : 4'b1111, 1, 1, 0);
        for (int i = 0; i < 20; i++) step(4'b1101, 1, 1, 0);
        for (int i = 0; i < 6; i++) step(((i / 2) % 2 == 0) ? 4'b1111 : 4'b1101, 1, 1, 0);
        for (int i = 0; i < 12; i++) step(4'b1111, 1, 1, 0);
        check("t2_tokens", tokens - t0, 1);
        check("t2_dir", tok_dir, 1);

        // 3: backpressure
        t0 = tokens;
        for (int i = 0; i < 20; i++) step((i < 12) ? 4'b0111 : 4'b1111, 1, 0, 0);
        check("t3_held_valid", int'(move_valid), 1);
        check("t3_held_dir", int'(move_dir), 3);
        for (int i = 0; i < 12; i++) step(4'b1111, 1, 1, 0);
        check("t3_tokens", tokens - t0, 1);
        check("t3_dir", tok_dir, 3);

        // 4: chord, then press while disabled
        t0 = tokens;
        for (int i = 0; i < 15; i++) step(4'b0110, 1, 1, 0);
        check("t4_chord_pressed", int'(pressed), 1);
        for (int i = 0; i < 12; i++) step(4'b1111, 1, 1, 0);
        for (int i = 0; i < 10; i++) step(4'b1011, 0, 1, 0);
        check("t4_gated_pressed", int'(pressed), 0);
        for (int i = 0; i < 10; i++) step(4'b1011, 1, 1, 0);
        check("t4_enable_valid", int'(move_valid), 0);
        check("t4_enable_pressed", int'(pressed), 0);
        check("t4_no_tokens", tokens - t0, 0);
        for (int i = 0; i < 4; i++) step(4'b1111, 1, 1, 0);
        for (int i = 0; i < 12; i++) step(4'b1011, 1, 1, 0);
        for (int i = 0; i < 12; i++) step(4'b1111, 1, 1, 0);
        check("t4_repress_tokens", tokens - t0, 1);
        check("t4_repress_dir", tok_dir, 2);

        // 5: reset while a token is pending
        t0 = tokens;
        seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            step(4'b1110, 1, 0, 0);
            seen = move_valid;
        end
        check("t5_issue_seen", int'(seen), 1);
        step(4'b1110, 1, 0, 1);
        check("t5_rst_valid", int'(move_valid), 0);
        check("t5_rst_dir", int'(move_dir), 0);
        check("t5_rst_pressed", int'(pressed), 0);
        n = 0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step(4'b1110, 1, 0, 0);
            n++;
            seen = move_valid;
        end
        check("t5_relatency", n, D + 3);
        step(4'b1110, 1, 1, 0);
        for (int i = 0; i < 12; i++) step(4'b1111, 1, 1, 0);
        check("t5_tokens", tokens - t0, 1);

        // 6: repeated press/release
        t0 = tokens;
        tok_dir_or = 0;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 10; i++) step(4'b1110, 1, 1, 0);
            for (int i = 0; i < 10; i++) step(4'b1111, 1, 1, 0);
        end
        check("t6_tokens", tokens - t0, 4);
        check("t6_dirs", tok_dir_or, 0);

        // random: held patterns of random length, enable mostly on, random ready
        for (int s = 0; s < 400; s++) begin
            b    = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 15));
            en   = ($urandom_range(0, 7) != 0);
            hold = $urandom_range(1, 12);
            for (int i = 0; i < hold; i++) step(b, en, 1'($urandom_range(0, 1)), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
